// File: rtl/fetch_queue.sv
// Instruction fetch unit: one outstanding imem read at a time feeding a 2-entry decode queue.
// States: IDLE = no read in flight | REQ = read in flight | DROP = superseded read in flight, data discarded.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [5:0]  opD,
    output logic [5:0]  functD
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_next;
    logic [31:0] r_addr;
    logic [31:0] w_addr_next;
    logic [1:0]  r_count;
    logic [1:0]  w_count_next;
    logic [31:0] r_instr0;
    logic [31:0] r_instr1;
    logic [31:0] r_pc0;
    logic [31:0] r_pc1;
    logic        w_enq;
    logic        w_deq;
    logic        w_wr_slot0;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign imem_req    = (r_state != S_IDLE);
    assign imem_addr   = r_addr;
    assign instr_valid = (r_count != 2'd0);
    assign instrD      = r_instr0;
    assign pcD         = r_pc0;
    assign opD         = r_instr0[31:26];
    assign functD      = r_instr0[5:0];

    assign w_target = redirect_pc & 32'hFFFF_FFFC;
    assign w_pc_inc = r_fetch_pc + 32'd4;

    // Redirect wins over both the dequeue and any returning data.
    assign w_deq        = instr_valid & instr_ready & ~redirect;
    assign w_enq        = (r_state == S_REQ) & imem_ack & ~redirect;
    assign w_count_next = redirect ? 2'd0 : (r_count + {1'b0, w_enq} - {1'b0, w_deq});
    assign w_wr_slot0   = ((r_count - {1'b0, w_deq}) == 2'd0);

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_addr_next     = r_addr;
        case (r_state)
            S_IDLE: begin
                if (redirect) begin
                    w_fetch_pc_next = w_target;
                end else if (w_count_next < 2'd2) begin
                    w_state_next = S_REQ;
                    w_addr_next  = r_fetch_pc;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    w_fetch_pc_next = w_target;
                    w_state_next    = imem_ack ? S_IDLE : S_DROP;
                end else if (imem_ack) begin
                    w_fetch_pc_next = w_pc_inc;
                    if (w_count_next < 2'd2) begin
                        w_addr_next = w_pc_inc;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (redirect) begin
                    w_fetch_pc_next = w_target;
                end
                if (imem_ack) begin
                    w_state_next = S_REQ;
                    w_addr_next  = w_fetch_pc_next;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_addr     <= w_addr_next;
        end
    end

    // Head lives in slot 0; a dequeue shifts slot 1 down, an enqueue fills the first free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= 2'd0;
            r_instr0 <= 32'd0;
            r_instr1 <= 32'd0;
            r_pc0    <= 32'd0;
            r_pc1    <= 32'd0;
        end else begin
            r_count <= w_count_next;
            if (w_deq) begin
                r_instr0 <= r_instr1;
                r_pc0    <= r_pc1;
            end
            if (w_enq) begin
                if (w_wr_slot0) begin
                    r_instr0 <= imem_rdata;
                    r_pc0    <= r_addr;
                end else begin
                    r_instr1 <= imem_rdata;
                    r_pc1    <= r_addr;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a queue-based reference model.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_ready = 1'b0;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instrD, pcD;
    logic [5:0]  opD, functD;
    logic        imem_req2, instr_valid2;
    logic [31:0] imem_addr2, instrD2, pcD2;
    logic [5:0]  opD2, functD2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fetch_queue #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instrD(instrD), .pcD(pcD), .opD(opD), .functD(functD)
    );

    fetch_queue #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid2), .instr_ready(instr_ready),
        .instrD(instrD2), .pcD(pcD2), .opD(opD2), .functD(functD2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        chk_addr;
        logic        chk_data;
    } vec_t;

    vec_t vecs[13];

    // Reference model: pending entries, one optional in-flight read, and whether its data is stale.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;
    ent_t        m_q[$];
    logic        m_out;
    logic        m_stale;
    logic [31:0] m_addr;
    logic [31:0] m_fpc;

    task automatic model_reset();
        m_q.delete();
        m_out = 1'b0;
        m_stale = 1'b0;
        m_addr = 32'h0;
        m_fpc = 32'h0;
    endtask

    task automatic model_step();
        logic deq, out_n, resume;
        if (rst) begin
            model_reset();
            return;
        end
        deq = (m_q.size() != 0) && instr_ready && !redirect;
        out_n = m_out;
        resume = 1'b0;
        if (deq) void'(m_q.pop_front());
        if (m_out && imem_ack) begin
            out_n = 1'b0;
            if (m_stale) begin
                resume = 1'b1;
            end else if (!redirect) begin
                m_q.push_back('{instr: imem_rdata, pc: m_addr});
                m_fpc = m_fpc + 32'd4;
            end
        end
        if (redirect) begin
            m_q.delete();
            m_fpc = {redirect_pc[31:2], 2'b00};
            if (out_n) m_stale = 1'b1;
        end
        if (!out_n) m_stale = 1'b0;
        if (!out_n && (resume || (!redirect && m_q.size() < 2))) begin
            out_n = 1'b1;
            m_addr = m_fpc;
        end
        m_out = out_n;
    endtask

    initial begin
        // Fill-and-drain with instant acks, then back-pressure with three acks offered.
        vecs[0]  = '{1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0,         32'h0, 1, 1};
        vecs[1]  = '{0, 0, 32'h0,         1, 1, 32'h0, 0, 32'h0,         32'h0, 1, 0};
        vecs[2]  = '{0, 1, 32'hA000_0001, 1, 1, 32'h4, 1, 32'hA000_0001, 32'h0, 1, 1};
        vecs[3]  = '{0, 1, 32'hA000_0002, 1, 1, 32'h8, 1, 32'hA000_0002, 32'h4, 1, 1};
        vecs[4]  = '{0, 1, 32'hA000_0003, 1, 1, 32'hC, 1, 32'hA000_0003, 32'h8, 1, 1};
        vecs[5]  = '{0, 0, 32'h0,         1, 1, 32'hC, 0, 32'h0,         32'h0, 1, 0};
        vecs[6]  = '{1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0,         32'h0, 0, 1};
        vecs[7]  = '{0, 0, 32'h0,         0, 1, 32'h0, 0, 32'h0,         32'h0, 1, 0};
        vecs[8]  = '{0, 1, 32'hB000_0001, 0, 1, 32'h4, 1, 32'hB000_0001, 32'h0, 1, 1};
        vecs[9]  = '{0, 1, 32'hB000_0002, 0, 0, 32'h0, 1, 32'hB000_0001, 32'h0, 0, 1};
        vecs[10] = '{0, 1, 32'hB000_0003, 0, 0, 32'h0, 1, 32'hB000_0001, 32'h0, 0, 1};
        vecs[11] = '{0, 0, 32'h0,         1, 1, 32'h8, 1, 32'hB000_0002, 32'h4, 1, 1};
        vecs[12] = '{0, 0, 32'h0,         0, 1, 32'h8, 1, 32'hB000_0002, 32'h4, 1, 1};

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            rst = vecs[i].rst; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
            instr_ready = vecs[i].ready; redirect = 1'b0;
            step();
            chk($sformatf("vec%0d req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("vec%0d valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
            if (vecs[i].chk_addr) chk($sformatf("vec%0d addr", i), imem_addr, vecs[i].e_addr);
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d instrD", i), instrD, vecs[i].e_instr);
                chk($sformatf("vec%0d pcD", i), pcD, vecs[i].e_pc);
                chk($sformatf("vec%0d opD", i), {26'd0, opD}, {26'd0, vecs[i].e_instr[31:26]});
                chk($sformatf("vec%0d functD", i), {26'd0, functD}, {26'd0, vecs[i].e_instr[5:0]});
            end
        end

        // Redirect while a read of 4 is pending: DROP holds 4, then refetch from 0x100.
        do_reset();
        step();
        imem_ack = 1'b1; imem_rdata = 32'hC000_0001;
        step();
        chk("drop pre addr", imem_addr, 32'h4);
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        chk("drop hold addr", imem_addr, 32'h4);
        chk("drop req", {31'd0, imem_req}, 32'd1);
        chk("drop flushed", {31'd0, instr_valid}, 32'd0);
        step();
        chk("drop hold addr2", imem_addr, 32'h4);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("drop next addr", imem_addr, 32'h100);
        chk("drop discard", {31'd0, instr_valid}, 32'd0);
        step();
        chk("drop still empty", {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hC000_0002;
        step();
        imem_ack = 1'b0;
        chk("drop refetch instr", instrD, 32'hC000_0002);
        chk("drop refetch pc", pcD, 32'h100);

        // Redirect coincident with the ack for address 8.
        do_reset();
        instr_ready = 1'b1;
        step();
        imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
        step();
        step();
        chk("coin pre addr", imem_addr, 32'h8);
        imem_rdata = 32'hBAD0_BAD0; redirect = 1'b1; redirect_pc = 32'h0000_2000;
        step();
        imem_ack = 1'b0; redirect = 1'b0;
        chk("coin req idle", {31'd0, imem_req}, 32'd0);
        chk("coin no enq", {31'd0, instr_valid}, 32'd0);
        step();
        chk("coin next addr", imem_addr, 32'h2000);
        chk("coin next req", {31'd0, imem_req}, 32'd1);
        chk("coin still empty", {31'd0, instr_valid}, 32'd0);

        // Address wrap from RESET_PC = 0xFFFF_FFFC.
        do_reset();
        instr_ready = 1'b0;
        step();
        chk("wrap first addr", imem_addr2, 32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'h2222_0000;
        step();
        imem_ack = 1'b0;
        chk("wrap second addr", imem_addr2, 32'h0);
        chk("wrap pcD", pcD2, 32'hFFFF_FFFC);

        // Asynchronous reset mid-request with one entry queued.
        do_reset();
        step();
        imem_ack = 1'b1; imem_rdata = 32'h3333_0000;
        step();
        imem_ack = 1'b0;
        chk("arst pre valid", {31'd0, instr_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst req drop", {31'd0, imem_req}, 32'd0);
        chk("arst valid drop", {31'd0, instr_valid}, 32'd0);
        chk("arst addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("arst restart addr", imem_addr, 32'h0);
        chk("arst restart req", {31'd0, imem_req}, 32'd1);
        chk("arst restart empty", {31'd0, instr_valid}, 32'd0);

        // Randomized traffic against the reference model.
        rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        model_reset();
        step();
        for (int c = 0; c < 3000; c++) begin
            chk("rnd req", {31'd0, imem_req}, {31'd0, m_out});
            chk("rnd valid", {31'd0, instr_valid}, {31'd0, (m_q.size() != 0)});
            if (m_out) chk("rnd addr", imem_addr, m_addr);
            if (m_q.size() != 0) begin
                chk("rnd instrD", instrD, m_q[0].instr);
                chk("rnd pcD", pcD, m_q[0].pc);
            end
            rst = (c > 0) && ($urandom_range(0, 99) == 0);
            imem_ack = ($urandom_range(0, 1) == 1);
            imem_rdata = $urandom;
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom;
            if (rst) model_reset();
            model_step();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; asynchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1, the instruction memory read request.
REQ-005 SHALL have port imem_addr, output, 32, the word-aligned request address.
REQ-006 SHALL have port imem_ack, input, 1, the memory completion strobe; imem_rdata is valid in that cycle.
REQ-007 SHALL have port imem_rdata, input, 32, the returned instruction word.
REQ-008 SHALL have port redirect, input, 1, the branch/jump taken pulse from decode/execute.
REQ-009 SHALL have port redirect_pc, input, 32, the new fetch target; bits [1:0] are ignored and treated as 00.
REQ-010 SHALL have port instr_valid, output, 1, the signal that the queue head holds an instruction for decode.
REQ-011 SHALL have port instr_ready, input, 1, the decode-stage accept signal.
REQ-012 SHALL have port instrD, output, 32, the queue-head instruction word.
REQ-013 SHALL have port pcD, output, 32, the address of instrD.
REQ-014 SHALL have ports opD and functD, output, 6 each, equal to instrD[31:26] and instrD[5:0], for the control decoder.

Function
REQ-015 SHALL hold a 2-entry FIFO of {instr, pc}; the head drives instrD/pcD; instr_valid = (count != 0).
REQ-016 SHALL dequeue the head on any cycle where instr_valid && instr_ready.
REQ-017 SHALL have FSM states IDLE, REQ and DROP; imem_req = 1 exactly in REQ and DROP.
REQ-018 SHALL hold imem_addr stable while imem_req = 1, and allow at most one outstanding request.
REQ-019 IDLE->REQ SHALL occur when (count_next + 0) < 2 and no redirect is present, with imem_addr = fetch_pc.
REQ-020 When REQ receives imem_ack without redirect, the block SHALL enqueue {imem_rdata, imem_addr}, set fetch_pc += 4 (mod 2^32, wrapping 32'hFFFF_FFFC -> 0), then go to REQ again if space remains after this cycle's enqueue/dequeue, else to IDLE.
REQ-021 A returned instruction SHALL become visible on instr_valid the cycle after imem_ack (1-cycle latency).
REQ-022 Redirect SHALL flush the FIFO (count = 0, instr_valid = 0 next cycle) and set fetch_pc = {redirect_pc[31:2],2'b00}; redirect overrides a simultaneous dequeue.
REQ-023 Redirect in REQ without ack SHALL move to DROP; DROP SHALL keep the old imem_addr until imem_ack, discard that data, then go to REQ at the new fetch_pc.
REQ-024 Redirect in REQ with ack in the same cycle SHALL discard the data and go to IDLE (no DROP).
REQ-025 Redirect in IDLE SHALL go to IDLE with the new fetch_pc; redirect in DROP SHALL only update fetch_pc (latest target wins).
REQ-026 The block SHALL never enqueue into a full FIFO; the request-issue rule guarantees count + outstanding <= 2.

Reset
REQ-027 While rst = 1, the block SHALL force state = IDLE, count = 0, fetch_pc = RESET_PC, imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instrD = 0, pcD = 0.
REQ-028 The first imem_req SHALL assert in the first clock cycle after rst deasserts; rst mid-request SHALL abandon the request without enqueue.

Verification
REQ-029 Reset release with imem_ack = 1 one cycle after each request and instr_ready = 1 -> addresses 0, 4, 8 are requested, instrD follows each rdata 1 cycle after ack, and pcD = 0, 4, 8.
REQ-030 instr_ready = 0 with 3 acks offered -> exactly 2 entries are queued, imem_req stays 0 with count = 2, and fetching resumes at addr 8 after one dequeue.
REQ-031 Redirect to 32'h0000_0103 while a request to 4 is pending without ack -> DROP holds addr 4, its data is discarded, the next request is to 32'h0000_0100, and the FIFO is empty meanwhile.
REQ-032 Redirect coincident with ack for addr 8 -> no enqueue of that data, and the next request is to redirect_pc.
REQ-033 RESET_PC = 32'hFFFF_FFFC -> the second request wraps to 0.
REQ-034 rst asserted asynchronously mid-REQ with count = 1 -> imem_req and instr_valid drop immediately, and fetch restarts at RESET_PC.
